// File: rtl/vend_actuator_seq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vend_actuator_seq_pkg: actuator sequencer states, counter width |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package vend_actuator_seq_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPENSE = 2'd1,
      ST_CHANGE   = 2'd2,
      ST_GAP      = 2'd3
   } act_state_t;

   // Saturating increment: sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_actuator_seq_edge.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | edge_pulse: 1-bit rising-edge detector                          |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module edge_pulse (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic r_q;

   // Reset loads the live input so a level already high at release is not an edge.
   always_ff @(posedge clk) begin
      if (!rst) r_q <= d;
      else      r_q <= d;
   end

   assign rise = d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/vend_actuator_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | vend_actuator_seq: dispense/change solenoid pulse sequencer     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module vend_actuator_seq
   import vend_actuator_seq_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic             r,
   output logic             disp_drv,
   output logic             chg_drv,
   output logic             busy,
   output logic [CNT_W-1:0] sales_cnt,
   output logic [CNT_W-1:0] chg_cnt,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] C_PULSE_LAST = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] C_GAP_LAST   = CNT_W'(GAP_LEN - 1);

   act_state_t       r_state;
   act_state_t       w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pend_s;
   logic             r_pend_r;
   logic             w_s_rise;
   logic             w_r_rise;
   logic             w_s_start;
   logic             w_r_start;

   edge_pulse u_edge_s (.clk(clk), .rst(rst), .d(s), .rise(w_s_rise));
   edge_pulse u_edge_r (.clk(clk), .rst(rst), .d(r), .rise(w_r_rise));

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_s_rise || r_pend_s)      w_next = ST_DISPENSE;
            else if (w_r_rise || r_pend_r) w_next = ST_CHANGE;
         end
         ST_DISPENSE, ST_CHANGE: begin
            if (r_cnt == C_PULSE_LAST) w_next = ST_GAP;
         end
         ST_GAP: begin
            if (r_cnt == C_GAP_LAST) begin
               if (r_pend_s)      w_next = ST_DISPENSE;
               else if (r_pend_r) w_next = ST_CHANGE;
               else               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign w_s_start = (w_next == ST_DISPENSE) && (r_state != ST_DISPENSE);
   assign w_r_start = (w_next == ST_CHANGE)   && (r_state != ST_CHANGE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_pend_s  <= 1'b0;
         r_pend_r  <= 1'b0;
         disp_drv  <= 1'b0;
         chg_drv   <= 1'b0;
         busy      <= 1'b0;
         sales_cnt <= '0;
         chg_cnt   <= '0;
         overrun   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= (w_next != r_state || r_state == ST_IDLE) ? '0 : r_cnt + CNT_W'(1);
         disp_drv <= (w_next == ST_DISPENSE);
         chg_drv  <= (w_next == ST_CHANGE);
         busy     <= (w_next != ST_IDLE);
         // A rise with its buffer already full is dropped, even if the buffer drains this cycle.
         r_pend_s <= w_s_start ? 1'b0 : (r_pend_s | w_s_rise);
         r_pend_r <= w_r_start ? 1'b0 : (r_pend_r | w_r_rise);
         overrun  <= overrun | (w_s_rise & r_pend_s) | (w_r_rise & r_pend_r);
         if (w_s_start) sales_cnt <= sat_inc(sales_cnt);
         if (w_r_start) chg_cnt   <= sat_inc(chg_cnt);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vend_actuator_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_vend_actuator_seq: randomized + directed bench with ref model|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_vend_actuator_seq;

   localparam int PULSE_LEN = 4;
   localparam int GAP_LEN   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       s   = 1'b0;
   logic       r   = 1'b0;
   logic       disp_drv;
   logic       chg_drv;
   logic       busy;
   logic [7:0] sales_cnt;
   logic [7:0] chg_cnt;
   logic       overrun;

   int checks = 0;
   int errors = 0;

   vend_actuator_seq #(.PULSE_LEN(PULSE_LEN), .GAP_LEN(GAP_LEN)) dut (
      .clk(clk), .rst(rst), .s(s), .r(r),
      .disp_drv(disp_drv), .chg_drv(chg_drv), .busy(busy),
      .sales_cnt(sales_cnt), .chg_cnt(chg_cnt), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference model: activity is "what is being driven" plus "cycles left".
   int  m_act;        // 0 none, 1 dispense, 2 change, 3 gap
   int  m_left;
   bit  m_want_s, m_want_r, m_prev_s, m_prev_r, m_lost;
   int  m_sales, m_chg;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_start(input int act);
      m_act  = act;
      m_left = PULSE_LEN;
      if (act == 1) begin
         m_want_s = 0;
         if (m_sales < 255) m_sales++;
      end else begin
         m_want_r = 0;
         if (m_chg < 255) m_chg++;
      end
   endtask

   task automatic model_edge(input bit si, input bit ri, input bit rsti);
      bit new_s, new_r, old_ws, old_wr, took_s, took_r;
      if (!rsti) begin
         m_act = 0; m_left = 0; m_want_s = 0; m_want_r = 0;
         m_lost = 0; m_sales = 0; m_chg = 0;
         m_prev_s = si; m_prev_r = ri;
         return;
      end
      new_s = si && !m_prev_s;
      new_r = ri && !m_prev_r;
      m_prev_s = si; m_prev_r = ri;
      old_ws = m_want_s; old_wr = m_want_r;
      if (new_s && old_ws) m_lost = 1;
      if (new_r && old_wr) m_lost = 1;
      took_s = 0; took_r = 0;
      if (m_act == 0) begin
         if (new_s || old_ws)      begin took_s = 1; model_start(1); end
         else if (new_r || old_wr) begin took_r = 1; model_start(2); end
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (m_act != 3) begin
               m_act = 3; m_left = GAP_LEN;
            end else if (old_ws) begin took_s = 1; model_start(1); end
            else if (old_wr)     begin took_r = 1; model_start(2); end
            else m_act = 0;
         end
      end
      if (!took_s && new_s) m_want_s = 1;
      if (!took_r && new_r) m_want_r = 1;
   endtask

   task automatic step(input bit si, input bit ri, input bit rsti);
      s = si; r = ri; rst = rsti;
      @(posedge clk);
      model_edge(si, ri, rsti);
      @(negedge clk);
      chk("disp_drv",  int'(disp_drv),  int'(m_act == 1));
      chk("chg_drv",   int'(chg_drv),   int'(m_act == 2));
      chk("busy",      int'(busy),      int'(m_act != 0));
      chk("sales_cnt", int'(sales_cnt), m_sales);
      chk("chg_cnt",   int'(chg_cnt),   m_chg);
      chk("overrun",   int'(overrun),   int'(m_lost));
      chk("mutex",     int'(disp_drv & chg_drv), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 1);
   endtask

   task automatic do_reset();
      step(0, 0, 0);
      step(0, 0, 0);
   endtask

   initial begin
      int busy_cycles;
      int disp_cycles;
      bit rs, rr;

      m_act = 0; m_left = 0; m_want_s = 0; m_want_r = 0;
      m_prev_s = 0; m_prev_r = 0; m_lost = 0; m_sales = 0; m_chg = 0;

      // Reset state
      do_reset();
      chk("rst_busy",  int'(busy), 0);
      chk("rst_sales", int'(sales_cnt), 0);
      chk("rst_ovr",   int'(overrun), 0);

      // Single sell pulse
      step(1, 0, 1);
      busy_cycles = int'(busy);
      disp_cycles = int'(disp_drv);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1);
         busy_cycles += int'(busy);
         disp_cycles += int'(disp_drv);
      end
      chk("single_busy_len", busy_cycles, 6);
      chk("single_disp_len", disp_cycles, 4);
      chk("single_sales",    int'(sales_cnt), 1);

      // Simultaneous sell and change
      do_reset();
      step(1, 1, 1);
      idle(14);
      chk("both_sales", int'(sales_cnt), 1);
      chk("both_chg",   int'(chg_cnt), 1);
      chk("both_ovr",   int'(overrun), 0);

      // Level held high gives one request
      do_reset();
      for (int i = 0; i < 20; i++) step(1, 0, 1);
      idle(10);
      chk("held_sales", int'(sales_cnt), 1);

      // Two extra rises during the first pulse
      do_reset();
      step(1, 0, 1); step(0, 0, 1); step(1, 0, 1);
      step(0, 0, 1); step(1, 0, 1); step(0, 0, 1);
      idle(16);
      chk("burst_sales", int'(sales_cnt), 2);
      chk("burst_ovr",   int'(overrun), 1);

      // Reset during the second dispense cycle
      do_reset();
      step(1, 1, 1);
      step(0, 0, 1);
      step(0, 0, 0);
      chk("midrst_disp", int'(disp_drv), 0);
      chk("midrst_busy", int'(busy), 0);
      idle(14);
      chk("midrst_chg",   int'(chg_cnt), 0);
      chk("midrst_sales", int'(sales_cnt), 0);

      // s high across reset release
      step(1, 0, 0);
      step(1, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 1);
      chk("relhigh_sales", int'(sales_cnt), 0);
      chk("relhigh_busy",  int'(busy), 0);

      // Randomized traffic with occasional reset
      do_reset();
      rs = 0; rr = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) rs = ~rs;
         if ($urandom_range(0, 4) == 0) rr = ~rr;
         step(rs, rr, ($urandom_range(0, 299) != 0));
      end

      // Counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(1, 0, 1);
         idle(7);
      end
      chk("sat_sales", int'(sales_cnt), 255);
      step(1, 0, 1);
      idle(7);
      chk("sat_hold", int'(sales_cnt), 255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
